imm_ext_unit: RTL and testbench

IMM_EXT_UNIT -- requirements
Module: imm_ext_unit

---
 rtl/imm_ext_unit.sv | 154 +++++++++++++++
 tb/tb_imm_ext_unit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/imm_ext_unit.sv
// rtl/imm_ext_unit.sv - immediate extension unit with a 2-entry registered skid buffer
// Optional feature macro: IMM_EXT_BYTE_MODE_EN (mode 11 = byte sign-extend; otherwise mode 11 = sign-extend)
module imm_ext_unit #(
    parameter int NB_EXTEND   = 32,
    parameter int NB_UNEXTEND = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_flush,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [1:0]             i_mode,
    input  logic [NB_UNEXTEND-1:0] i_unextended,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [NB_EXTEND-1:0]   o_extended
);

    // Number of fill bits above the raw immediate; zero when widths match.
    localparam int NB_PAD = NB_EXTEND - NB_UNEXTEND;

    localparam logic [1:0] MODE_SEXT  = 2'b00;
    localparam logic [1:0] MODE_ZEXT  = 2'b01;
    localparam logic [1:0] MODE_UPPER = 2'b10;
    localparam logic [1:0] MODE_BYTE  = 2'b11;

    // Buffer occupancy: how many results are held (main first, then skid).
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    state_e                 state_q;
    state_e                 state_d;
    logic                   ready_q;
    logic                   ready_d;
    logic [NB_EXTEND-1:0]   main_q;
    logic [NB_EXTEND-1:0]   main_d;
    logic [NB_EXTEND-1:0]   skid_q;
    logic [NB_EXTEND-1:0]   skid_d;

    logic [NB_EXTEND-1:0]   sext_val;
    logic [NB_EXTEND-1:0]   zext_val;
    logic [NB_EXTEND-1:0]   upper_val;
    logic [NB_EXTEND-1:0]   ext_val;
    logic                   push;
    logic                   pop;

    // Width casts handle the equal-width case without zero-width replications.
    assign sext_val  = NB_EXTEND'($signed(i_unextended));
    assign zext_val  = NB_EXTEND'(i_unextended);
    assign upper_val = zext_val << NB_PAD;

`ifdef IMM_EXT_BYTE_MODE_EN
    logic [NB_EXTEND-1:0]   byte_val;

    assign byte_val = NB_EXTEND'($signed(i_unextended[7:0]));

    // Select the extension rule for the incoming immediate, byte mode included.
    always_comb begin
        ext_val = sext_val;
        case (i_mode)
            MODE_SEXT:  ext_val = sext_val;
            MODE_ZEXT:  ext_val = zext_val;
            MODE_UPPER: ext_val = upper_val;
            MODE_BYTE:  ext_val = byte_val;
            default:    ext_val = sext_val;
        endcase
    end
`else
    // Select the extension rule; without byte mode, mode 11 falls back to sign-extend.
    always_comb begin
        ext_val = sext_val;
        case (i_mode)
            MODE_SEXT:  ext_val = sext_val;
            MODE_ZEXT:  ext_val = zext_val;
            MODE_UPPER: ext_val = upper_val;
            default:    ext_val = sext_val;
        endcase
    end
`endif

    // Handshake events; ready comes from a flop so upstream never sees i_ready.
    assign o_valid    = (state_q != ST_EMPTY);
    assign o_ready    = ready_q;
    assign o_extended = main_q;
    assign push       = i_valid && ready_q;
    assign pop        = o_valid && i_ready;

    // Next occupancy and buffer contents; flush wins over any push or pop.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (i_flush) begin
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        main_d  = ext_val;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        // Oldest leaves this edge, so the new result becomes head.
                        main_d  = ext_val;
                        state_d = ST_ONE;
                    end else if (push) begin
                        skid_d  = ext_val;
                        state_d = ST_TWO;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // Ready is low here, so only a pop can occur.
                    if (pop) begin
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // Ready is low only when both entries are occupied after this edge.
    always_comb begin
        ready_d = (state_d != ST_TWO);
    end

    // State and data registers; reset empties the buffer and blocks input for one edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_EMPTY;
            ready_q <= 1'b0;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_imm_ext_unit.sv
// tb/tb_imm_ext_unit.sv - self-checking bench for imm_ext_unit against a queue reference model
module tb_imm_ext_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        valid = 1'b0;
    logic        rdy = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [15:0] din = 16'h0;
    logic        o_ready;
    logic        o_valid;
    logic [31:0] o_ext;

    int checks = 0;
    int errors = 0;

    logic [31:0] q[$];
    logic        m_ready = 1'b0;
    logic        hold_prev = 1'b0;
    logic [31:0] prev_data = 32'h0;

    always #5 clk = ~clk;

    imm_ext_unit #(.NB_EXTEND(32), .NB_UNEXTEND(16)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_flush      (flush),
        .i_valid      (valid),
        .o_ready      (o_ready),
        .i_mode       (mode),
        .i_unextended (din),
        .o_valid      (o_valid),
        .i_ready      (rdy),
        .o_extended   (o_ext)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Arithmetic statement of the extension rules.
    function automatic logic [31:0] ref_ext(input logic [1:0] m, input logic [15:0] v);
        longint unsigned u;
        longint unsigned b;
        longint unsigned r;
        u = longint'(v);
        b = u % 256;
        if (u >= 32768) r = u + 64'd4294967296 - 64'd65536;
        else r = u;
        case (m)
            2'b01: r = u;
            2'b10: r = u * 65536;
`ifdef IMM_EXT_BYTE_MODE_EN
            2'b11: r = (b >= 128) ? (b + 64'd4294967296 - 64'd256) : b;
`endif
            default: ;
        endcase
        return r[31:0];
    endfunction

    // One clock: check outputs against the model, drive inputs, advance model, step to next negedge.
    task automatic cycle(input logic v, input logic [1:0] m, input logic [15:0] d,
                         input logic r, input logic f);
        bit push;
        bit pop;
        if (hold_prev) check("stable", {31'h0, o_valid, o_ext}, {31'h0, 1'b1, prev_data});
        check("ready", o_ready, m_ready);
        check("valid", o_valid, q.size() > 0);
        if (q.size() > 0) check("data", o_ext, q[0]);
        valid = v; mode = m; din = d; rdy = r; flush = f;
        push = v && m_ready;
        pop  = (q.size() > 0) && r;
        hold_prev = (q.size() > 0) && !r && !f;
        prev_data = o_ext;
        if (f) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(ref_ext(m, d));
        end
        m_ready = (q.size() < 2);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        check("rst_valid", o_valid, 1'b0);
        check("rst_ready", o_ready, 1'b0);
        check("rst_data", o_ext, 32'h0);
        rst_n = 1'b1;
        // Offered input on the first edge after release must be ignored.
        cycle(1'b1, 2'b00, 16'h1234, 1'b1, 1'b0);
        check("post_rst_ready", o_ready, 1'b1);
        check("post_rst_no_accept", o_valid, 1'b0);

        // Sign-extend pair.
        cycle(1'b1, 2'b00, 16'h8001, 1'b1, 1'b0);
        check("m00_neg", o_ext, 32'hFFFF8001);
        cycle(1'b1, 2'b00, 16'h7FFF, 1'b1, 1'b0);
        check("m00_pos", o_ext, 32'h00007FFF);
        cycle(1'b0, 2'b00, 16'h0, 1'b1, 1'b0);

        // Zero, upper and byte modes.
        cycle(1'b1, 2'b01, 16'hABCD, 1'b1, 1'b0);
        check("m01", o_ext, 32'h0000ABCD);
        cycle(1'b1, 2'b10, 16'hABCD, 1'b1, 1'b0);
        check("m10", o_ext, 32'hABCD0000);
        cycle(1'b1, 2'b11, 16'h1280, 1'b1, 1'b0);
`ifdef IMM_EXT_BYTE_MODE_EN
        check("m11", o_ext, 32'hFFFFFF80);
`else
        check("m11", o_ext, 32'h00001280);
`endif
        cycle(1'b0, 2'b00, 16'h0, 1'b1, 1'b0);

        // Back-pressure: A and B buffered, C held off, then drained in order.
        cycle(1'b1, 2'b00, 16'h0001, 1'b0, 1'b0);
        cycle(1'b1, 2'b00, 16'h0002, 1'b0, 1'b0);
        check("full_ready", o_ready, 1'b0);
        cycle(1'b1, 2'b00, 16'h0003, 1'b0, 1'b0);
        check("held_a", o_ext, 32'h1);
        cycle(1'b1, 2'b00, 16'h0003, 1'b1, 1'b0);
        check("order_b", o_ext, 32'h2);
        cycle(1'b1, 2'b00, 16'h0003, 1'b1, 1'b0);
        check("order_c", o_ext, 32'h3);
        cycle(1'b0, 2'b00, 16'h0, 1'b1, 1'b0);
        check("drained", o_valid, 1'b0);

        // Flush while full, with push and pop offered.
        cycle(1'b1, 2'b00, 16'h0005, 1'b0, 1'b0);
        cycle(1'b1, 2'b00, 16'h0006, 1'b0, 1'b0);
        cycle(1'b1, 2'b00, 16'h0007, 1'b1, 1'b1);
        check("flush_valid", o_valid, 1'b0);
        check("flush_ready", o_ready, 1'b1);
        cycle(1'b0, 2'b00, 16'h0, 1'b1, 1'b0);

        // Asynchronous reset mid-cycle while one entry is held.
        cycle(1'b1, 2'b00, 16'h8009, 1'b0, 1'b0);
        valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_valid", o_valid, 1'b0);
        check("async_data", o_ext, 32'h0);
        check("async_ready", o_ready, 1'b0);
        q.delete();
        m_ready = 1'b0;
        hold_prev = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 2'b00, 16'h0, 1'b1, 1'b0);
        check("async_rel_ready", o_ready, 1'b1);

        // Random traffic at 50% valid/ready.
        for (int i = 0; i < 10000; i++) begin
            cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom),
                  1'($urandom_range(0, 1)), 1'b0);
        end
        cycle(1'b0, 2'b00, 16'h0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
